// File: rtl/upc_chk_pkg.sv
// upc_chk_pkg: shared types and default sizes for the micro-PC checkpoint sequencer
package upc_chk_pkg;

    localparam int DEF_UPC_W = 12;
    localparam int DEF_NCHK  = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        DONE    = 3'd2,
        FAIL    = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    // One checkpoint: a from->to back-jump plus an optional redirect target
    typedef struct packed {
        logic                 en;
        logic [DEF_UPC_W-1:0] from;
        logic [DEF_UPC_W-1:0] to;
        logic                 rel;
        logic                 redir;
        logic [DEF_UPC_W-1:0] target;
    } chk_entry_t;

endpackage

// File: rtl/upc_checkpoint_sequencer_if.sv
// upc_checkpoint_sequencer_if: micro-PC observation and redirect bus between control unit and sequencer
interface upc_checkpoint_sequencer_if #(
    parameter int UPC_W = upc_chk_pkg::DEF_UPC_W
);
    logic [UPC_W-1:0] upc_x;
    logic [UPC_W-1:0] upc_f;
    logic             upc_valid;
    logic             redir_valid;
    logic [UPC_W-1:0] redir_addr;

    modport master (
        output upc_x, upc_f, upc_valid,
        input  redir_valid, redir_addr
    );

    modport slave (
        input  upc_x, upc_f, upc_valid,
        output redir_valid, redir_addr
    );
endinterface

// File: rtl/upc_chk_match.sv
// upc_chk_match: compares the uPC pair against every checkpoint and picks the lowest matching index
module upc_chk_match
    import upc_chk_pkg::*;
#(
    parameter int NCHK  = DEF_NCHK,
    parameter int IDX_W = $clog2(NCHK)
) (
    input  chk_entry_t           tbl [NCHK],
    input  logic [NCHK-1:0]      mask,
    input  logic [DEF_UPC_W-1:0] upc_x,
    input  logic [DEF_UPC_W-1:0] upc_f,
    input  logic                 en,
    output logic                 hit,
    output logic [IDX_W-1:0]     idx
);

    logic [NCHK-1:0] vec;

    for (genvar i = 0; i < NCHK; i++) begin : g_cmp
        assign vec[i] = en && tbl[i].en && !mask[i] && upc_x == tbl[i].from && upc_f == tbl[i].to;
    end

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        hit = |vec;
        idx = '0;
        for (int i = NCHK - 1; i >= 0; i--)
            if (vec[i]) idx = IDX_W'(i);
    end

endmodule

// File: rtl/upc_checkpoint_sequencer.sv
// upc_checkpoint_sequencer: microcode self-test sequencer that scores checkpoint back-jumps, fail label and watchdog
module upc_checkpoint_sequencer
    import upc_chk_pkg::*;
#(
    parameter int UPC_W  = DEF_UPC_W,
    parameter int NCHK   = DEF_NCHK,
    parameter int IDX_W  = $clog2(NCHK),
    parameter int WDOG_W = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    upc_checkpoint_sequencer_if.slave cu,
    input  logic                      start,
    input  logic                      cfg_we,
    input  logic [IDX_W-1:0]          cfg_idx,
    input  logic                      cfg_en,
    input  logic [UPC_W-1:0]          cfg_from,
    input  logic [UPC_W-1:0]          cfg_to,
    input  logic                      cfg_rel,
    input  logic                      cfg_redir,
    input  logic [UPC_W-1:0]          cfg_target,
    input  logic [UPC_W-1:0]          fail_label,
    input  logic [WDOG_W-1:0]         wdog_limit,
    output logic                      pass_pulse,
    output logic [IDX_W-1:0]          pass_idx,
    output logic [NCHK-1:0]           pass_mask,
    output logic [IDX_W:0]            pass_count,
    output logic [2:0]                state,
    output logic                      cfg_err
);

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_RUN     = RUN;
    localparam logic [2:0] ST_DONE    = DONE;
    localparam logic [2:0] ST_FAIL    = FAIL;
    localparam logic [2:0] ST_TIMEOUT = TIMEOUT;

    chk_entry_t        tbl [NCHK];
    logic [NCHK-1:0]   en_vec;
    logic [WDOG_W-1:0] wdog;
    logic              run;
    logic              fail_hit;
    logic              all_done;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    chk_entry_t        hit_e;

    for (genvar i = 0; i < NCHK; i++) begin : g_en
        assign en_vec[i] = tbl[i].en;
    end

    assign run      = state == ST_RUN;
    assign fail_hit = cu.upc_valid && cu.upc_x == fail_label;
    assign all_done = &(pass_mask | ~en_vec);
    assign hit_e    = tbl[hit_idx];

    // Matching is held off while a redirect is outstanding: upc_x/upc_f still show the old path
    upc_chk_match #(.NCHK(NCHK), .IDX_W(IDX_W)) u_match (
        .tbl   (tbl),
        .mask  (pass_mask),
        .upc_x (cu.upc_x),
        .upc_f (cu.upc_f),
        .en    (run && cu.upc_valid && !cu.redir_valid && !fail_hit),
        .hit   (hit),
        .idx   (hit_idx)
    );

    // Sequencer FSM, checkpoint table, pass bookkeeping, redirect register and watchdog
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            pass_pulse     <= 1'b0;
            pass_idx       <= '0;
            pass_mask      <= '0;
            pass_count     <= '0;
            cfg_err        <= 1'b0;
            wdog           <= '0;
            cu.redir_valid <= 1'b0;
            cu.redir_addr  <= '0;
            for (int i = 0; i < NCHK; i++) tbl[i] <= '0;
        end else begin
            pass_pulse     <= 1'b0;
            cu.redir_valid <= 1'b0;
            cfg_err        <= cfg_we && run;
            if (cfg_we && !run)
                tbl[cfg_idx] <= '{en: cfg_en, from: cfg_from, to: cfg_to, rel: cfg_rel,
                                  redir: cfg_redir, target: cfg_target};
            if (run) begin
                if (fail_hit) begin
                    state <= ST_FAIL;
                end else if (hit) begin
                    pass_pulse         <= 1'b1;
                    pass_idx           <= hit_idx;
                    pass_mask[hit_idx] <= 1'b1;
                    pass_count         <= pass_count + (IDX_W+1)'(1);
                    wdog               <= '0;
                    cu.redir_valid     <= hit_e.redir;
                    cu.redir_addr      <= hit_e.rel ? cu.upc_x + hit_e.target : hit_e.target;
                end else if (all_done) begin
                    state <= ST_DONE;
                end else begin
                    wdog <= wdog + WDOG_W'(1);
                    if (wdog_limit != '0 && wdog == wdog_limit) state <= ST_TIMEOUT;
                end
            end else if (start) begin
                state      <= |en_vec ? ST_RUN : ST_DONE;
                pass_mask  <= '0;
                pass_count <= '0;
                wdog       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_upc_checkpoint_sequencer.sv
// tb_upc_checkpoint_sequencer: directed scoreboard bench for the checkpoint sequencer
module tb_upc_checkpoint_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_idx = '0;
    logic        cfg_en = 1'b0;
    logic [11:0] cfg_from = '0;
    logic [11:0] cfg_to = '0;
    logic        cfg_rel = 1'b0;
    logic        cfg_redir = 1'b0;
    logic [11:0] cfg_target = '0;
    logic [11:0] fail_label = 12'hFFF;
    logic [19:0] wdog_limit = '0;
    logic        pass_pulse;
    logic [4:0]  pass_idx;
    logic [31:0] pass_mask;
    logic [5:0]  pass_count;
    logic [2:0]  state;
    logic        cfg_err;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [4:0]  idx;
        logic        rv;
        logic [11:0] addr;
    } exp_t;

    exp_t q[$];
    exp_t e;

    upc_checkpoint_sequencer_if #(.UPC_W(12)) cu ();

    upc_checkpoint_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cu         (cu),
        .start      (start),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_en     (cfg_en),
        .cfg_from   (cfg_from),
        .cfg_to     (cfg_to),
        .cfg_rel    (cfg_rel),
        .cfg_redir  (cfg_redir),
        .cfg_target (cfg_target),
        .fail_label (fail_label),
        .wdog_limit (wdog_limit),
        .pass_pulse (pass_pulse),
        .pass_idx   (pass_idx),
        .pass_mask  (pass_mask),
        .pass_count (pass_count),
        .state      (state),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [4:0] idx, input logic rv, input logic [11:0] addr);
        q.push_back('{idx: idx, rv: rv, addr: addr});
    endtask

    task automatic drive(input logic v, input logic [11:0] x, input logic [11:0] f);
        cu.upc_valid = v;
        cu.upc_x = x;
        cu.upc_f = f;
    endtask

    task automatic cfg(input logic [4:0] idx, input logic en, input logic [11:0] from,
                       input logic [11:0] to, input logic rel, input logic redir,
                       input logic [11:0] target);
        cfg_idx = idx;
        cfg_en = en;
        cfg_from = from;
        cfg_to = to;
        cfg_rel = rel;
        cfg_redir = redir;
        cfg_target = target;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Monitor: every pass or redirect the DUT presents must match the head of the scoreboard
    always @(posedge clk) begin
        #1;
        if (reset && (pass_pulse || cu.redir_valid)) begin
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: pass=%0b idx=%0d redir=%0b addr=%0d, expected no event",
                         pass_pulse, pass_idx, cu.redir_valid, cu.redir_addr);
            end else begin
                e = q.pop_front();
                if (pass_pulse !== 1'b1 || pass_idx !== e.idx || cu.redir_valid !== e.rv ||
                    (e.rv && cu.redir_addr !== e.addr)) begin
                    errors++;
                    $display("FAIL pass_event: got pass=%0b idx=%0d redir=%0b addr=%0d, expected pass=1 idx=%0d redir=%0b addr=%0d",
                             pass_pulse, pass_idx, cu.redir_valid, cu.redir_addr, e.idx, e.rv, e.addr);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, '0, '0);
        tick();
        tick();
        chk("reset_state", 32'(state), 0);
        chk("reset_pass_pulse", 32'(pass_pulse), 0);
        chk("reset_redir_valid", 32'(cu.redir_valid), 0);
        chk("reset_pass_mask", pass_mask, 0);
        chk("reset_pass_count", 32'(pass_count), 0);
        chk("reset_cfg_err", 32'(cfg_err), 0);
        reset = 1'b1;
        tick();

        cfg(5'd0, 1'b1, 12'd6, 12'd1, 1'b1, 1'b1, 12'd2);
        cfg(5'd1, 1'b1, 12'd20, 12'd21, 1'b0, 1'b1, 12'd100);
        chk("idle_cfg_no_err", 32'(cfg_err), 0);
        pulse_start();
        chk("run_after_start", 32'(state), 1);
        drive(1'b1, 12'd6, 12'd1);
        push(5'd0, 1'b1, 12'd8);
        tick();
        drive(1'b0, '0, '0);
        tick();
        drive(1'b1, 12'd20, 12'd21);
        push(5'd1, 1'b1, 12'd100);
        tick();
        drive(1'b0, '0, '0);
        chk("two_entry_count", 32'(pass_count), 2);
        chk("two_entry_mask", pass_mask, 32'h3);
        tick();
        chk("two_entry_done", 32'(state), 2);

        cfg(5'd0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0);
        cfg(5'd1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0);
        cfg(5'd3, 1'b1, 12'd30, 12'd31, 1'b0, 1'b0, 12'd0);
        cfg(5'd5, 1'b1, 12'd30, 12'd31, 1'b0, 1'b0, 12'd0);
        pulse_start();
        chk("prio_run", 32'(state), 1);
        drive(1'b1, 12'd30, 12'd31);
        push(5'd3, 1'b0, 12'd0);
        push(5'd5, 1'b0, 12'd0);
        tick();
        chk("prio_first_count", 32'(pass_count), 1);
        tick();
        drive(1'b0, '0, '0);
        chk("prio_count", 32'(pass_count), 2);
        chk("prio_mask", pass_mask, 32'h28);
        tick();
        chk("prio_done", 32'(state), 2);

        cfg(5'd3, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0);
        cfg(5'd5, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0);
        cfg(5'd0, 1'b1, 12'd7, 12'd8, 1'b0, 1'b1, 12'd50);
        fail_label = 12'd7;
        pulse_start();
        drive(1'b1, 12'd7, 12'd8);
        tick();
        drive(1'b0, '0, '0);
        chk("fail_state", 32'(state), 3);
        chk("fail_no_count", 32'(pass_count), 0);
        tick();
        chk("fail_sticky", 32'(state), 3);

        fail_label = 12'hFFF;
        wdog_limit = 20'd10;
        pulse_start();
        repeat (5) tick();
        chk("wdog_still_run", 32'(state), 1);
        repeat (7) tick();
        chk("wdog_timeout", 32'(state), 4);

        wdog_limit = 20'd0;
        pulse_start();
        repeat (1000) tick();
        chk("wdog_disabled_run", 32'(state), 1);

        cfg(5'd0, 1'b1, 12'd4094, 12'd9, 1'b1, 1'b1, 12'd5);
        chk("run_cfg_err_pulse", 32'(cfg_err), 1);
        tick();
        chk("run_cfg_err_clear", 32'(cfg_err), 0);
        drive(1'b1, 12'd4094, 12'd9);
        tick();
        drive(1'b1, 12'd7, 12'd8);
        push(5'd0, 1'b1, 12'd50);
        tick();
        drive(1'b0, '0, '0);
        tick();
        chk("unchanged_table_done", 32'(state), 2);

        cfg(5'd0, 1'b1, 12'd4094, 12'd9, 1'b1, 1'b1, 12'd5);
        pulse_start();
        drive(1'b1, 12'd4094, 12'd9);
        push(5'd0, 1'b1, 12'd3);
        tick();
        drive(1'b0, '0, '0);
        tick();
        chk("wrap_done", 32'(state), 2);
        chk("wrap_count", 32'(pass_count), 1);

        pulse_start();
        chk("midrun_run", 32'(state), 1);
        drive(1'b1, 12'd4094, 12'd9);
        push(5'd0, 1'b1, 12'd3);
        tick();
        drive(1'b0, '0, '0);
        #2;
        reset = 1'b0;
        #1;
        chk("midrun_state", 32'(state), 0);
        chk("midrun_pass_pulse", 32'(pass_pulse), 0);
        chk("midrun_redir_valid", 32'(cu.redir_valid), 0);
        chk("midrun_pass_mask", pass_mask, 0);
        chk("midrun_pass_count", 32'(pass_count), 0);
        tick();
        reset = 1'b1;
        tick();
        pulse_start();
        chk("empty_table_done", 32'(state), 2);

        tick();
        tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/upc_checkpoint_sequencer.md
Name: upc_checkpoint_sequencer

Overview:
- Synthesizable microcode self-test sequencer for the micro-BESM CPU; sits beside the control unit's micro-PC.
- Watches execution-stage and fetch-stage micro-PC for configured "from→to" back-jumps, meaning a test loop has completed.
- On each match: records a pass and optionally redirects uPC to a target, absolute or relative.
- Also detects a fail label and a no-progress watchdog, so initest-style runs work in hardware and on FPGA, not only in a bench.

Parameters:
- UPC_W, 12, micro-PC width.
- NCHK, 32, number of checkpoint table entries.
- IDX_W, $clog2(NCHK), checkpoint index width.
- WDOG_W, 20, watchdog counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- upc_x  in  UPC_W  micro-PC of instruction in execute stage.
- upc_f  in  UPC_W  micro-PC being fetched.
- upc_valid  in  1  upc_x/upc_f valid this cycle; pipeline not stalled.
- start  in  1  arm sequencer, pulse.
- cfg_we  in  1  checkpoint table write strobe.
- cfg_idx  in  IDX_W  entry written.
- cfg_en  in  1  entry enable.
- cfg_from  in  UPC_W  execute-stage label.
- cfg_to  in  UPC_W  fetch-stage label.
- cfg_rel  in  1  1 means target = upc_x + cfg_target (mod 2^UPC_W); 0 means absolute.
- cfg_redir  in  1  entry requests redirect.
- cfg_target  in  UPC_W  target address or offset.
- fail_label  in  UPC_W  execute-stage address meaning test failure.
- wdog_limit  in  WDOG_W  cycles allowed between passes.
- redir_valid  out  1  one-cycle redirect request to control unit.
- redir_addr  out  UPC_W  redirect address.
- pass_pulse  out  1  one-cycle pass event.
- pass_idx  out  IDX_W  index of entry that passed.
- pass_mask  out  NCHK  sticky per-entry pass bits.
- pass_count  out  IDX_W+1  number of entries passed.
- state  out  3  encoded FSM state.
- cfg_err  out  1  one-cycle pulse on rejected config write.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0 and state=IDLE.
  - Table entries disabled; wdog counter 0.
- FSM states: IDLE=0, RUN=1, DONE=2, FAIL=3, TIMEOUT=4.
  - IDLE: cfg_we writes the table entry at the next edge. start → RUN, clearing pass_mask, pass_count and wdog.
  - RUN: cfg_we is ignored; cfg_err pulses the following cycle.
  - DONE, FAIL, TIMEOUT: sticky; start returns to RUN and clears as for IDLE. cfg_we is accepted only from IDLE or a terminal state.
- Match, RUN only, when upc_valid=1: entry i matches if enabled, pass_mask[i]=0, upc_x==from[i] and upc_f==to[i].
  - Lowest matching index wins; other matches are evaluated again next cycle.
- On a match, registered, one cycle later:
  - pass_pulse=1, pass_idx=i, pass_mask[i]<=1, pass_count+1, wdog<=0.
  - If redir[i]=1: redir_valid=1, redir_addr = target or upc_x+target (the upc_x latched at match), wrapping at UPC_W bits.
  - An entry passes at most once per run.
- Fail: upc_valid && upc_x==fail_label in RUN → FAIL next cycle.
  - Fail takes priority over any simultaneous match; that match gives no pass and no redirect.
- Watchdog: in RUN, wdog increments every clk regardless of upc_valid.
  - wdog==wdog_limit → TIMEOUT.
  - If wdog_limit==0 the watchdog is disabled.
  - A pass in the same cycle as the limit wins and clears wdog.
- DONE: the cycle after pass_mask covers every enabled entry.
  - If no entry is enabled, start goes directly to DONE next cycle.
- Latency: match to pass_pulse/redir_valid is exactly 1 cycle.
  - While redir_valid is asserted, matching is suppressed for that cycle, because upc_x/upc_f are stale.
- Reset mid-run: immediate return to IDLE. The table is cleared and must be reloaded.

Decomposition:
- Package upc_chk_pkg holds:
  - state_t enum (IDLE/RUN/DONE/FAIL/TIMEOUT).
  - chk_entry_t struct: en, from, to, rel, redir, target.
  - Default UPC_W and NCHK.
- Sub-module upc_chk_match: combinational NCHK-wide comparator with a lowest-index priority encoder. Outputs hit and idx.
- The FSM, table, redirect register and watchdog live in the top module.

Test Plan:
- Entry 0 {from=6, to=1, rel, redir, target=2}, start, drive upc_x=6, upc_f=1 → next cycle pass_pulse, pass_idx=0, redir_addr=8; two-entry config then reaches DONE.
- Entries 3 and 5 both match in the same cycle → pass_idx=3 first, then 5 the following cycle; pass_count=2.
- fail_label=7, drive upc_x=7 while entry 0 also matches → state=FAIL, no pass_pulse, no redir_valid.
- wdog_limit=10, no matches → state=TIMEOUT after 10 cycles in RUN; with wdog_limit=0, no timeout after 1000 cycles.
- Rel entry with upc_x=4094, target=5 → redir_addr=3 (12-bit wrap); cfg_we during RUN → cfg_err pulse, table unchanged.
- Deassert reset (drive low) mid-RUN → all outputs 0, state=IDLE; a subsequent start with no entries → DONE.
